// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter for four valid/ready/last streams sharing one 4:1 mux.
// A grant is held until the granted requester's last beat transfers.
module mux4_rr_arbiter #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [3:0]         req_valid,
  input  logic [3:0]         req_last,
  input  logic [4*WIDTH-1:0] req_data,
  output logic [3:0]         req_ready,
  output logic               out_valid,
  output logic [WIDTH-1:0]   out_data,
  output logic               out_last,
  input  logic               out_ready,
  output logic [1:0]         sel,
  output logic [3:0]         grant,
  output logic               busy
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t     state_r, state_s;
  logic [1:0] ptr_r, ptr_s;
  logic [1:0] sel_r, sel_s;
  logic [3:0] grant_r, grant_s;
  logic       busy_r, busy_s;
  logic [1:0] winner_s;
  logic       xfer_s;

  // Rotate requests so ptr lands on bit 0, take the lowest set bit, rotate back.
  function automatic logic [1:0] rr_pick(input logic [3:0] req, input logic [1:0] ptr);
    logic [7:0] dbl;
    logic [3:0] rot;
    logic [1:0] k;
    dbl = {req, req} >> ptr;
    rot = dbl[3:0];
    if (rot[0]) begin
      k = 2'd0;
    end else if (rot[1]) begin
      k = 2'd1;
    end else if (rot[2]) begin
      k = 2'd2;
    end else begin
      k = 2'd3;
    end
    return ptr + k;
  endfunction

  assign sel      = sel_r;
  assign grant    = grant_r;
  assign busy     = busy_r;
  assign winner_s = rr_pick(req_valid, ptr_r);
  assign xfer_s   = out_valid && out_ready;

  // Output mux and handshake steering toward the granted requester.
  always_comb begin
    out_data  = req_data[sel_r*WIDTH +: WIDTH];
    out_last  = req_last[sel_r];
    out_valid = 1'b0;
    req_ready = 4'b0000;
    if (state_r == GRANT) begin
      out_valid        = req_valid[sel_r];
      req_ready[sel_r] = out_ready;
    end else begin
      out_valid = 1'b0;
      req_ready = 4'b0000;
    end
  end

  // Next-state logic: grant on any request, release only on an accepted last beat.
  always_comb begin
    state_s = state_r;
    ptr_s   = ptr_r;
    sel_s   = sel_r;
    grant_s = grant_r;
    busy_s  = busy_r;
    case (state_r)
      IDLE: begin
        if (|req_valid) begin
          state_s = GRANT;
          sel_s   = winner_s;
          grant_s = 4'b0001 << winner_s;
          busy_s  = 1'b1;
        end else begin
          state_s = IDLE;
        end
      end
      GRANT: begin
        if (xfer_s && out_last) begin
          state_s = IDLE;
          grant_s = 4'b0000;
          busy_s  = 1'b0;
          ptr_s   = sel_r + 2'd1;
        end else begin
          state_s = GRANT;
        end
      end
      default: begin
        state_s = IDLE;
        ptr_s   = 2'd0;
        sel_s   = 2'd0;
        grant_s = 4'b0000;
        busy_s  = 1'b0;
      end
    endcase
  end

  // State registers; reset wins over any transfer in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      ptr_r   <= 2'd0;
      sel_r   <= 2'd0;
      grant_r <= 4'b0000;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      ptr_r   <= ptr_s;
      sel_r   <= sel_s;
      grant_r <= grant_s;
      busy_r  <= busy_s;
    end
  end

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Bench for mux4_rr_arbiter: per-requester beat sources plus an ordered
// scoreboard of the beats expected on the output side.
module tb_mux4_rr_arbiter;

  localparam int WIDTH = 8;

  typedef struct {
    logic [7:0] data;
    logic       last;
  } beat_t;

  typedef struct {
    logic [1:0] id;
    logic [7:0] data;
    logic       last;
  } exp_t;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic [3:0]         req_valid = 4'b0000;
  logic [3:0]         req_last = 4'b0000;
  logic [4*WIDTH-1:0] req_data = '0;
  logic [3:0]         req_ready;
  logic               out_valid;
  logic [WIDTH-1:0]   out_data;
  logic               out_last;
  logic               out_ready = 1'b0;
  logic [1:0]         sel;
  logic [3:0]         grant;
  logic               busy;

  beat_t      src_q[4][$];
  exp_t       sb_q[$];
  logic [3:0] hold = 4'b0000;
  logic       last_xfer;
  logic       idle_req;
  int         n_tests = 0;
  int         n_fail = 0;

  mux4_rr_arbiter #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_last(req_last), .req_data(req_data),
    .req_ready(req_ready),
    .out_valid(out_valid), .out_data(out_data), .out_last(out_last),
    .out_ready(out_ready),
    .sel(sel), .grant(grant), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int pending();
    int n;
    n = 0;
    for (int i = 0; i < 4; i++) n += src_q[i].size();
    return n;
  endfunction

  // Queue a beat at a requester; optionally record it as an expected output beat.
  task automatic load(input int id, input logic [7:0] data, input logic last, input bit expect_out);
    beat_t b;
    exp_t  e;
    b.data = data;
    b.last = last;
    src_q[id].push_back(b);
    if (expect_out) begin
      e.id   = 2'(id);
      e.data = data;
      e.last = last;
      sb_q.push_back(e);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < 4; i++) begin
      if (src_q[i].size() > 0 && !hold[i]) begin
        req_valid[i]               = 1'b1;
        req_last[i]                = src_q[i][0].last;
        req_data[i*WIDTH +: WIDTH] = src_q[i][0].data;
      end else begin
        req_valid[i]               = 1'b0;
        req_last[i]                = 1'($urandom_range(0, 1));
        req_data[i*WIDTH +: WIDTH] = 8'($urandom);
      end
    end
  endtask

  // One clock: sample/score at negedge, advance sources after posedge.
  task automatic step();
    logic [3:0] fire;
    exp_t       e;
    beat_t      dummy;
    @(negedge clk);
    fire      = 4'b0000;
    last_xfer = 1'b0;
    idle_req  = 1'b0;
    if (!rst) begin
      fire = req_valid & req_ready;
      check_val("ready_onehot", 32'($countones(req_ready) <= 1), 32'd1);
      if (grant == 4'b0000) begin
        check_val("idle_no_data", 32'(out_valid), 32'd0);
        idle_req = |req_valid;
      end
      if (out_valid && out_ready) begin
        last_xfer = out_last;
        if (sb_q.size() == 0) begin
          check_val("sb_extra_beat", 32'(sb_q.size()), 32'd1);
        end else begin
          e = sb_q.pop_front();
          check_val("beat_sel", 32'(sel), 32'(e.id));
          check_val("beat_grant", 32'(grant), 32'(4'b0001 << e.id));
          check_val("beat_data", 32'(out_data), 32'(e.data));
          check_val("beat_last", 32'(out_last), 32'(e.last));
        end
      end
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      if (fire[i]) dummy = src_q[i].pop_front();
    end
    drive();
    #1;
    if (last_xfer) check_val("bubble", 32'(grant), 32'd0);
    else if (idle_req) check_val("arb_latency", 32'(grant != 4'b0000), 32'd1);
  endtask

  task automatic run_until_done(input int budget);
    int cnt;
    cnt = 0;
    while ((sb_q.size() > 0 || pending() > 0) && cnt < budget) begin
      step();
      cnt++;
    end
    check_val("done_in_budget", 32'(cnt < budget), 32'd1);
  endtask

  initial begin
    drive();
    step();
    step();
    check_val("rst_grant", 32'(grant), 32'd0);
    check_val("rst_sel", 32'(sel), 32'd0);
    check_val("rst_busy", 32'(busy), 32'd0);
    check_val("rst_out_valid", 32'(out_valid), 32'd0);
    check_val("rst_req_ready", 32'(req_ready), 32'd0);

    // Single request from requester 2
    rst       = 1'b0;
    out_ready = 1'b1;
    load(2, 8'hA5, 1'b1, 1'b1);
    drive();
    #1;
    check_val("pre_grant", 32'(grant), 32'd0);
    check_val("pre_grant_valid", 32'(out_valid), 32'd0);
    step();
    check_val("t1_grant", 32'(grant), 32'h4);
    check_val("t1_sel", 32'(sel), 32'd2);
    check_val("t1_busy", 32'(busy), 32'd1);
    check_val("t1_out_valid", 32'(out_valid), 32'd1);
    check_val("t1_out_data", 32'(out_data), 32'hA5);
    check_val("t1_req_ready", 32'(req_ready), 32'h4);
    step();
    check_val("t1_busy_after", 32'(busy), 32'd0);
    check_val("t1_valid_after", 32'(out_valid), 32'd0);

    // ptr=3 now: all four valid -> 3,0,1,2,3
    load(3, 8'h30, 1'b1, 1'b1);
    load(0, 8'h10, 1'b1, 1'b1);
    load(1, 8'h11, 1'b1, 1'b1);
    load(2, 8'h12, 1'b1, 1'b1);
    load(3, 8'h34, 1'b1, 1'b1);
    drive();
    #1;
    run_until_done(60);

    // Burst lock: requester 1 three beats, requester 0 arrives mid-burst
    load(1, 8'h21, 1'b0, 1'b1);
    load(1, 8'h22, 1'b0, 1'b1);
    load(1, 8'h23, 1'b1, 1'b1);
    drive();
    #1;
    step();
    check_val("t3_grant", 32'(grant), 32'h2);
    load(0, 8'h24, 1'b1, 1'b1);
    drive();
    #1;
    run_until_done(30);

    // Backpressure then valid gap on requester 3
    load(3, 8'h31, 1'b0, 1'b1);
    load(3, 8'h32, 1'b1, 1'b1);
    out_ready = 1'b0;
    drive();
    #1;
    step();
    for (int k = 0; k < 4; k++) begin
      check_val("bp_grant", 32'(grant), 32'h8);
      check_val("bp_out_valid", 32'(out_valid), 32'd1);
      check_val("bp_out_data", 32'(out_data), 32'h31);
      check_val("bp_req_ready", 32'(req_ready), 32'd0);
      step();
    end
    out_ready = 1'b1;
    #1;
    step();
    hold[3] = 1'b1;
    load(0, 8'h50, 1'b1, 1'b1);
    drive();
    #1;
    for (int k = 0; k < 2; k++) begin
      check_val("gap_out_valid", 32'(out_valid), 32'd0);
      check_val("gap_grant", 32'(grant), 32'h8);
      step();
    end
    hold[3] = 1'b0;
    drive();
    #1;
    run_until_done(30);

    // Wrap: 3 completes, then 0 and 3 together -> 0 first
    load(3, 8'h61, 1'b1, 1'b1);
    drive();
    #1;
    run_until_done(20);
    load(0, 8'h62, 1'b1, 1'b1);
    load(3, 8'h63, 1'b1, 1'b1);
    drive();
    #1;
    run_until_done(30);

    // Move ptr to 2 so the post-reset pick shows ptr was cleared
    load(1, 8'h71, 1'b1, 1'b1);
    drive();
    #1;
    run_until_done(20);

    // Reset during the 2nd beat of a 4-beat burst from requester 2
    load(2, 8'h81, 1'b0, 1'b1);
    load(2, 8'h82, 1'b0, 1'b0);
    load(2, 8'h83, 1'b0, 1'b0);
    load(2, 8'h84, 1'b1, 1'b0);
    drive();
    #1;
    step();
    check_val("t6_grant", 32'(grant), 32'h4);
    step();
    check_val("t6_second_beat", 32'(out_data), 32'h82);
    rst = 1'b1;
    step();
    check_val("t6_rst_grant", 32'(grant), 32'd0);
    check_val("t6_rst_valid", 32'(out_valid), 32'd0);
    check_val("t6_rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    src_q[2].delete();
    load(1, 8'h91, 1'b1, 1'b1);
    load(2, 8'h92, 1'b1, 1'b1);
    drive();
    #1;
    run_until_done(30);

    check_val("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
